// File: rtl/run_sequencer.sv
// Program-run controller: picks an entry address, pulses the core's Start,
// then times the run until the core acks, the host aborts or the watchdog fires.
module run_sequencer #(
  parameter int                PW        = 10,
  parameter int                CW        = 16,
  parameter int                START_LEN = 2,
  parameter logic [CW-1:0]     TIMEOUT   = 16'hFFFF,
  parameter logic [PW-1:0]     BASE0     = 10'h000,
  parameter logic [PW-1:0]     BASE1     = 10'h080,
  parameter logic [PW-1:0]     BASE2     = 10'h100,
  parameter logic [PW-1:0]     BASE3     = 10'h180
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic [1:0]    ProgSel,
  input  logic          Abort,
  input  logic          DoneAck,
  input  logic          CoreAck,
  output logic          CoreStart,
  output logic [PW-1:0] PCInit,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
  output logic [1:0]    RunIdx,
  output logic [CW-1:0] CycleCt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_TMO    = 3'd4
  } state_t;

  localparam logic [3:0]    LAST_LAUNCH = 4'(START_LEN - 1);
  localparam logic [CW-1:0] LAST_COUNT  = TIMEOUT - CW'(1);

  state_t        state_q, state_d;
  logic [3:0]    lcnt_q, lcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          core_start_q, busy_q, done_q, tmo_q;

  function automatic logic [PW-1:0] base_sel(input logic [1:0] sel);
    logic [PW-1:0] addr;
    case (sel)
      2'd0:    addr = BASE0;
      2'd1:    addr = BASE1;
      2'd2:    addr = BASE2;
      2'd3:    addr = BASE3;
      default: addr = BASE0;
    endcase
    return addr;
  endfunction

  // Next-state and datapath update; Abort outranks CoreAck, which outranks the watchdog.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          idx_d   = ProgSel;
          pc_d    = base_sel(ProgSel);
          cyc_d   = '0;
          lcnt_d  = 4'd0;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        lcnt_d = lcnt_q + 4'd1;
        if (Abort) begin
          state_d = S_IDLE;
        end else if (lcnt_q == LAST_LAUNCH) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (CoreAck) begin
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CW'(1);
          if (cyc_q == LAST_COUNT) begin
            state_d = S_TMO;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE, S_TMO: begin
        if (DoneAck) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and status flags; flags are decoded from the next state so they stay registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      lcnt_q       <= 4'd0;
      cyc_q        <= '0;
      idx_q        <= 2'd0;
      pc_q         <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      pc_q         <= pc_d;
      core_start_q <= (state_d == S_LAUNCH);
      busy_q       <= (state_d == S_LAUNCH) || (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
      tmo_q        <= (state_d == S_TMO);
    end
  end

  assign CoreStart = core_start_q;
  assign PCInit    = pc_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign TimedOut  = tmo_q;
  assign RunIdx    = idx_q;
  assign CycleCt   = cyc_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer; expected results come from a per-run
// arithmetic model of how each program run must end.
module tb_run_sequencer;

  localparam int          PW        = 10;
  localparam int          CW        = 16;
  localparam int          START_LEN = 2;
  localparam int          TMO       = 20;
  localparam logic [15:0] TMO_LIM   = 16'd20;

  logic          clk = 1'b0;
  logic          rst, go, abort, done_ack, core_ack;
  logic [1:0]    prog_sel;
  logic          CoreStart, Busy, Done, TimedOut;
  logic [PW-1:0] PCInit;
  logic [1:0]    RunIdx;
  logic [CW-1:0] CycleCt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  run_sequencer #(.PW(PW), .CW(CW), .START_LEN(START_LEN), .TIMEOUT(TMO_LIM)) dut (
    .Clk(clk), .Reset(rst), .Go(go), .ProgSel(prog_sel), .Abort(abort),
    .DoneAck(done_ack), .CoreAck(core_ack), .CoreStart(CoreStart), .PCInit(PCInit),
    .Busy(Busy), .Done(Done), .TimedOut(TimedOut), .RunIdx(RunIdx), .CycleCt(CycleCt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int base_of(input int sel);
    return sel * 128;
  endfunction

  // Called and returning at a negedge with the DUT idle. ack_at/abort_at are
  // 1-based RUN-cycle numbers (abort_at=0: no abort).
  task automatic run_prog(input int sel, input int ack_at, input int abort_at,
                          input bit stale, input bit go_hold);
    int  cnt, r, exp_ct, exp_r;
    bit  aborted, timed;
    go = 1'b1; prog_sel = 2'(sel); core_ack = stale;
    @(negedge clk);
    go = go_hold;
    check_eq("pcinit", 32'(PCInit), 32'(base_of(sel)));
    check_eq("runidx_launch", 32'(RunIdx), 32'(sel));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!CoreStart) break;
      cnt++;
      prog_sel = 2'($urandom);
      @(negedge clk);
    end
    check_eq("start_len", 32'(cnt), 32'(START_LEN));
    check_eq("busy_run", 32'(Busy), 32'(1));
    for (r = 1; r <= TMO + 6; r++) begin
      core_ack = (r >= ack_at);
      abort    = (r == abort_at);
      prog_sel = 2'($urandom);
      @(negedge clk);
      if (!Busy) break;
    end
    abort = 1'b0; core_ack = 1'b0;
    aborted = (abort_at > 0) && (abort_at <= ack_at) && (abort_at <= TMO);
    timed   = !aborted && (ack_at > TMO);
    exp_ct  = aborted ? abort_at - 1 : (timed ? TMO : ack_at - 1);
    exp_r   = aborted ? abort_at : (timed ? TMO : ack_at);
    check_eq("run_len", 32'(r), 32'(exp_r));
    check_eq("busy_end", 32'(Busy), 32'(0));
    check_eq("start_end", 32'(CoreStart), 32'(0));
    check_eq("done", 32'(Done), 32'(!aborted && !timed));
    check_eq("timedout", 32'(TimedOut), 32'(timed));
    check_eq("cyclect", 32'(CycleCt), 32'(exp_ct));
    check_eq("runidx", 32'(RunIdx), 32'(sel));
    check_eq("pcinit_end", 32'(PCInit), 32'(base_of(sel)));
    if (!aborted) begin
      for (int k = 0; k < 2; k++) begin
        go = 1'b1; prog_sel = 2'($urandom);
        @(negedge clk);
        check_eq("hold_done", 32'(Done), 32'(!timed));
        check_eq("hold_tmo", 32'(TimedOut), 32'(timed));
        check_eq("hold_ct", 32'(CycleCt), 32'(exp_ct));
        check_eq("hold_idx", 32'(RunIdx), 32'(sel));
      end
      go = go_hold; done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      check_eq("ack_busy", 32'(Busy), 32'(0));
      check_eq("ack_done", 32'(Done), 32'(0));
      check_eq("ack_tmo", 32'(TimedOut), 32'(0));
      check_eq("idle_ct", 32'(CycleCt), 32'(exp_ct));
      check_eq("idle_idx", 32'(RunIdx), 32'(sel));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [CW-1:0] ct_snap;
    int ack_at, abort_at, stale, hold;
    rst = 1'b1; go = 1'b0; abort = 1'b0; done_ack = 1'b0; core_ack = 1'b0; prog_sel = 2'd0;
    #1;
    check_eq("rst_start", 32'(CoreStart), 32'(0));
    check_eq("rst_busy", 32'(Busy), 32'(0));
    check_eq("rst_done", 32'(Done), 32'(0));
    check_eq("rst_tmo", 32'(TimedOut), 32'(0));
    check_eq("rst_pc", 32'(PCInit), 32'(0));
    check_eq("rst_idx", 32'(RunIdx), 32'(0));
    check_eq("rst_ct", 32'(CycleCt), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    run_prog(2, 7, 0, 1'b0, 1'b0);        // ack on 7th RUN cycle
    run_prog(1, 1, 0, 1'b1, 1'b0);        // stale ack through LAUNCH
    run_prog(3, TMO + 5, 0, 1'b0, 1'b0);  // watchdog
    run_prog(0, TMO, 0, 1'b0, 1'b0);      // ack at the last count wins
    run_prog(2, TMO + 5, 6, 1'b0, 1'b0);  // abort at CycleCt=5

    ct_snap = CycleCt;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check_eq("idle_abort_busy", 32'(Busy), 32'(0));
    check_eq("idle_abort_ct", 32'(CycleCt), 32'(ct_snap));

    go = 1'b1; prog_sel = 2'd3;
    @(negedge clk);
    go = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("launch_abort_busy", 32'(Busy), 32'(0));
    check_eq("launch_abort_start", 32'(CoreStart), 32'(0));
    check_eq("launch_abort_ct", 32'(CycleCt), 32'(0));

    run_prog(0, 3, 0, 1'b0, 1'b1);        // Go held through DONE/DoneAck
    run_prog(3, 5, 0, 1'b0, 1'b0);

    go = 1'b1; prog_sel = 2'd3;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(Busy), 32'(0));
    check_eq("mid_rst_start", 32'(CoreStart), 32'(0));
    check_eq("mid_rst_ct", 32'(CycleCt), 32'(0));
    check_eq("mid_rst_pc", 32'(PCInit), 32'(0));
    check_eq("mid_rst_idx", 32'(RunIdx), 32'(0));
    check_eq("mid_rst_flags", 32'({Done, TimedOut}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    run_prog(1, 4, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ack_at   = int'($urandom_range(1, TMO + 3));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO + 2)) : 0;
      stale    = int'($urandom_range(0, 1));
      hold     = (i < 15) ? int'($urandom_range(0, 1)) : 0;
      run_prog(int'($urandom_range(0, 3)), ack_at, abort_at, stale[0], hold[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
